// File: rtl/vga_timing_controller_if.sv
// Raster output bundle from vga_timing_controller to pattern generators.
// frame_count is present only when VGA_TIMING_FRAME_COUNT_EN is defined.
interface vga_timing_controller_if #(
    parameter int C_bits = 10
);
    logic              hsync;
    logic              vsync;
    logic              blank;
    logic [C_bits-1:0] x;
    logic [C_bits-1:0] y;
    logic              line_start;
    logic              frame_start;
`ifdef VGA_TIMING_FRAME_COUNT_EN
    logic [7:0]        frame_count;

    modport master (output hsync, vsync, blank, x, y, line_start, frame_start, frame_count);
    modport slave  (input  hsync, vsync, blank, x, y, line_start, frame_start, frame_count);
`else
    modport master (output hsync, vsync, blank, x, y, line_start, frame_start);
    modport slave  (input  hsync, vsync, blank, x, y, line_start, frame_start);
`endif
endinterface

// File: rtl/vga_timing_controller.sv
// Programmable raster sequencer: counters plus per-axis phase FSMs, registered outputs.
// Optional 8-bit frame counter enabled by defining VGA_TIMING_FRAME_COUNT_EN.
module vga_timing_controller #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int H_SYNC_POL = 0,
    parameter int V_SYNC_POL = 0,
    parameter int C_bits     = 10
) (
    input  logic                     clk_pixel,
    input  logic                     reset,
    input  logic                     enable,
    vga_timing_controller_if.master  vid
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [C_bits-1:0] H_LAST     = C_bits'(H_TOTAL - 1);
    localparam logic [C_bits-1:0] H_FP_START = C_bits'(H_VISIBLE);
    localparam logic [C_bits-1:0] H_SY_START = C_bits'(H_VISIBLE + H_FRONT);
    localparam logic [C_bits-1:0] H_BP_START = C_bits'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [C_bits-1:0] V_LAST     = C_bits'(V_TOTAL - 1);
    localparam logic [C_bits-1:0] V_FP_START = C_bits'(V_VISIBLE);
    localparam logic [C_bits-1:0] V_SY_START = C_bits'(V_VISIBLE + V_FRONT);
    localparam logic [C_bits-1:0] V_BP_START = C_bits'(V_VISIBLE + V_FRONT + V_SYNC);

    localparam logic H_ACT = (H_SYNC_POL != 0);
    localparam logic V_ACT = (V_SYNC_POL != 0);

    // Every phase must be at least one unit wide or the FSM would skip a state.
    generate
        if (H_VISIBLE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
            V_VISIBLE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_phase
            $error("vga_timing_controller: every timing parameter must be >= 1");
        end
        if ((H_TOTAL - 1) >= (1 << C_bits) || (V_TOTAL - 1) >= (1 << C_bits)) begin : g_bad_width
            $error("vga_timing_controller: C_bits too narrow for H_TOTAL/V_TOTAL");
        end
    endgenerate

    typedef enum logic [1:0] {
        PH_VISIBLE,
        PH_FRONT,
        PH_SYNC,
        PH_BACK
    } phase_t;

    typedef struct packed {
        logic              hsync;
        logic              vsync;
        logic              blank;
        logic [C_bits-1:0] x;
        logic [C_bits-1:0] y;
        logic              line_start;
        logic              frame_start;
    } raster_t;

    logic [C_bits-1:0] hcount, vcount;
    logic [C_bits-1:0] h_next, v_next;
    logic              h_wrap, v_wrap;
    phase_t            h_phase, v_phase;
    raster_t           out_q;

    always_comb begin
        h_wrap = (hcount == H_LAST);
        v_wrap = (vcount == V_LAST);
        h_next = h_wrap ? '0 : hcount + 1'b1;
        v_next = v_wrap ? '0 : vcount + 1'b1;
    end

    // Phase registers move on the same edge the counter lands on a boundary,
    // so (count, phase) are always mutually consistent and outputs decode phase.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            hcount            <= '0;
            vcount            <= '0;
            h_phase           <= PH_VISIBLE;
            v_phase           <= PH_VISIBLE;
            out_q.hsync       <= ~H_ACT;
            out_q.vsync       <= ~V_ACT;
            out_q.blank       <= 1'b1;
            out_q.x           <= '0;
            out_q.y           <= '0;
            out_q.line_start  <= 1'b0;
            out_q.frame_start <= 1'b0;
        end else if (enable) begin
            hcount <= h_next;
            unique case (h_phase)
                PH_VISIBLE: if (h_next == H_FP_START) h_phase <= PH_FRONT;
                PH_FRONT:   if (h_next == H_SY_START) h_phase <= PH_SYNC;
                PH_SYNC:    if (h_next == H_BP_START) h_phase <= PH_BACK;
                PH_BACK:    if (h_wrap)               h_phase <= PH_VISIBLE;
                default:                              h_phase <= PH_VISIBLE;
            endcase

            if (h_wrap) begin
                vcount <= v_next;
                unique case (v_phase)
                    PH_VISIBLE: if (v_next == V_FP_START) v_phase <= PH_FRONT;
                    PH_FRONT:   if (v_next == V_SY_START) v_phase <= PH_SYNC;
                    PH_SYNC:    if (v_next == V_BP_START) v_phase <= PH_BACK;
                    PH_BACK:    if (v_wrap)               v_phase <= PH_VISIBLE;
                    default:                              v_phase <= PH_VISIBLE;
                endcase
            end

            out_q.hsync       <= (h_phase == PH_SYNC) ? H_ACT : ~H_ACT;
            out_q.vsync       <= (v_phase == PH_SYNC) ? V_ACT : ~V_ACT;
            out_q.blank       <= !(h_phase == PH_VISIBLE && v_phase == PH_VISIBLE);
            out_q.x           <= hcount;
            out_q.y           <= vcount;
            out_q.line_start  <= (hcount == '0);
            out_q.frame_start <= (hcount == '0) && (vcount == '0);
        end
    end

    assign vid.hsync       = out_q.hsync;
    assign vid.vsync       = out_q.vsync;
    assign vid.blank       = out_q.blank;
    assign vid.x           = out_q.x;
    assign vid.y           = out_q.y;
    assign vid.line_start  = out_q.line_start;
    assign vid.frame_start = out_q.frame_start;

`ifdef VGA_TIMING_FRAME_COUNT_EN
    logic [7:0] frame_cnt_q;

    // Bumps on the edge that registers frame_start high.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            frame_cnt_q <= '0;
        end else if (enable && hcount == '0 && vcount == '0) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    assign vid.frame_count = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_controller.sv
// Directed bench on a reduced raster: H 10/2/3/2 (17 px), V 4/1/2/1 (8 lines), 136 clocks per frame.
module tb_vga_timing_controller;
    logic clk = 1'b0;
    logic reset;
    logic enable;

    int n_vec = 0;
    int n_err = 0;
    int hlow_cnt = 0;

    always #5 clk = ~clk;

    vga_timing_controller_if #(.C_bits(10)) vid ();

    vga_timing_controller #(
        .H_VISIBLE(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(4),  .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .H_SYNC_POL(0), .V_SYNC_POL(0), .C_bits(10)
    ) dut (
        .clk_pixel (clk),
        .reset     (reset),
        .enable    (enable),
        .vid       (vid)
    );

    always @(negedge clk) if (vid.hsync === 1'b0) hlow_cnt <= hlow_cnt + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_hsync"}, vid.hsync, 1);
        chk({tag, "_vsync"}, vid.vsync, 1);
        chk({tag, "_blank"}, vid.blank, 1);
        chk({tag, "_x"}, vid.x, 0);
        chk({tag, "_y"}, vid.y, 0);
        chk({tag, "_ls"}, vid.line_start, 0);
        chk({tag, "_fs"}, vid.frame_start, 0);
`ifdef VGA_TIMING_FRAME_COUNT_EN
        chk({tag, "_fc"}, vid.frame_count, 0);
`endif
    endtask

    initial begin
        int hl, vl, lsn, fsn, ub, vs_bad, vs_edge_bad, hbase;
        logic prev_vs;

        reset  = 1'b1;
        enable = 1'b0;
        tick(3);
        chk_reset_state("rst");

        // first enabled edge shows raster origin
        reset  = 1'b0;
        enable = 1'b1;
        tick(1);
        chk("first_fs", vid.frame_start, 1);
        chk("first_ls", vid.line_start, 1);
        chk("first_blank", vid.blank, 0);
        chk("first_x", vid.x, 0);
        chk("first_y", vid.y, 0);
        chk("first_hsync", vid.hsync, 1);
`ifdef VGA_TIMING_FRAME_COUNT_EN
        chk("first_fc", vid.frame_count, 1);
`endif

        // line boundaries
        tick(9);
        chk("x9", vid.x, 9);
        chk("x9_blank", vid.blank, 0);
        chk("x9_ls", vid.line_start, 0);
        tick(1);
        chk("x10_blank", vid.blank, 1);
        chk("x10_hsync", vid.hsync, 1);
        tick(1);
        chk("x11_hsync", vid.hsync, 1);
        tick(1);
        chk("x12_hsync", vid.hsync, 0);
        tick(2);
        chk("x14_hsync", vid.hsync, 0);
        tick(1);
        chk("x15_hsync", vid.hsync, 1);
        tick(1);
        chk("x16", vid.x, 16);
        tick(1);
        chk("l1_x", vid.x, 0);
        chk("l1_y", vid.y, 1);
        chk("l1_ls", vid.line_start, 1);
        chk("l1_fs", vid.frame_start, 0);
        chk("l1_blank", vid.blank, 0);

        // one full frame of statistics starting at (0,1)
        hl = 0; vl = 0; lsn = 0; fsn = 0; ub = 0; vs_bad = 0; vs_edge_bad = 0;
        prev_vs = vid.vsync;
        for (int i = 0; i < 136; i++) begin
            tick(1);
            if (!vid.hsync) hl++;
            if (!vid.vsync) begin
                vl++;
                if (vid.y != 5 && vid.y != 6) vs_bad++;
            end
            if (vid.line_start) lsn++;
            if (vid.frame_start) fsn++;
            if (!vid.blank) ub++;
            if (vid.vsync !== prev_vs && vid.x != 0) vs_edge_bad++;
            prev_vs = vid.vsync;
        end
        chk("frm_hsync_low", hl, 24);
        chk("frm_vsync_low", vl, 34);
        chk("frm_vsync_rows", vs_bad, 0);
        chk("frm_vsync_align", vs_edge_bad, 0);
        chk("frm_ls_count", lsn, 8);
        chk("frm_fs_count", fsn, 1);
        chk("frm_visible", ub, 40);
        chk("frm_end_x", vid.x, 0);
        chk("frm_end_y", vid.y, 1);

        // frame wrap: (16,7) -> (0,0)
        tick(118);
        chk("wrap_pre_x", vid.x, 16);
        chk("wrap_pre_y", vid.y, 7);
        chk("wrap_pre_fs", vid.frame_start, 0);
        tick(1);
        chk("wrap_x", vid.x, 0);
        chk("wrap_y", vid.y, 0);
        chk("wrap_fs", vid.frame_start, 1);
        chk("wrap_ls", vid.line_start, 1);

        // freeze inside the hsync pulse stretches it by the stall length
        tick(12);
        chk("frz_start_hsync", vid.hsync, 0);
        hbase = hlow_cnt;
        tick(1);
        chk("frz_x13", vid.x, 13);
        enable = 1'b0;
        tick(5);
        chk("frz_x", vid.x, 13);
        chk("frz_y", vid.y, 0);
        chk("frz_hsync", vid.hsync, 0);
        chk("frz_blank", vid.blank, 1);
        enable = 1'b1;
        tick(1);
        chk("frz_x14", vid.x, 14);
        chk("frz_x14_hsync", vid.hsync, 0);
        tick(1);
        chk("frz_x15_hsync", vid.hsync, 1);
        chk("frz_pulse_len", hlow_cnt - hbase, 8);

        // reset in the middle of both sync pulses at (13,5)
        tick(83);
        chk("mid_x", vid.x, 13);
        chk("mid_y", vid.y, 5);
        chk("mid_vsync", vid.vsync, 0);
        chk("mid_hsync", vid.hsync, 0);
        reset = 1'b1;
        tick(1);
        chk_reset_state("mrst");
        reset = 1'b0;
        tick(1);
        chk("mrst_fs", vid.frame_start, 1);
        chk("mrst_ls", vid.line_start, 1);
        chk("mrst_x", vid.x, 0);
        chk("mrst_blank", vid.blank, 0);

`ifdef VGA_TIMING_FRAME_COUNT_EN
        chk("fc_1", vid.frame_count, 1);
        for (int f = 1; f <= 256; f++) begin
            tick(136);
            chk("fc_fs", vid.frame_start, 1);
            chk("fc_val", vid.frame_count, (f + 1) % 256);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/vga_timing_controller.md
Name: vga_timing_controller

Overview:
Programmable raster sequencer that drives the pixel-clock video datapath. It generates hsync, vsync, blank, pixel coordinates and frame/line strobes. These feed the pattern generator and, in turn, the VGA-to-HDMI serializer front end. It replaces fixed timing inside pattern generators, so any generator can be scheduled against one shared raster.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
H_SYNC_POL, 0, asserted level of hsync (0 = active low)
V_SYNC_POL, 0, asserted level of vsync (0 = active low)
C_bits, 10, width of coordinate and counter outputs; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
clk_pixel  input  1  pixel clock; sole clock domain
reset  input  1  synchronous, active-high reset
enable  input  1  advance raster when 1; freeze all state when 0
hsync  output  1  horizontal sync at H_SYNC_POL
vsync  output  1  vertical sync at V_SYNC_POL
blank  output  1  1 outside the visible area
x  output  C_bits  horizontal counter value
y  output  C_bits  vertical counter value
line_start  output  1  one-cycle pulse at hcount==0
frame_start  output  1  one-cycle pulse at hcount==0 and vcount==0

Behaviour:
- Derived totals: H_TOTAL = sum of the four H parameters (default 800); V_TOTAL = sum of the four V parameters (default 525).
- Clocking and reset: single clock clk_pixel. reset is synchronous and active-high.
- Counters hcount and vcount:
  - Reset to 0.
  - When enable=1: hcount increments; at H_TOTAL-1 it wraps to 0 and vcount increments; at V_TOTAL-1 (with the hcount wrap) vcount wraps to 0.
  - When enable=0: counters and all outputs hold.
- Per-axis phase FSM (horizontal and vertical, identical structure): VISIBLE -> FRONT -> SYNC -> BACK -> VISIBLE.
  - Horizontal: a transition occurs on the cycle the counter reaches a phase boundary: H_VISIBLE, H_VISIBLE+H_FRONT, +H_SYNC, H_TOTAL (wrap).
  - Vertical: transitions are evaluated only on hcount wrap.
  - The FSM is the decode source for the sync and blank outputs, not a comparator chain on the raw count.
- Outputs are registered with 1-cycle latency: outputs at cycle n+1 reflect counter state (h,v) at cycle n.
  - hsync asserted iff horizontal phase == SYNC.
  - vsync asserted iff vertical phase == SYNC. vsync changes aligned with hcount==0.
  - blank = 0 iff both phases == VISIBLE.
  - x = hcount, y = vcount, unmasked.
  - line_start = (hcount==0); frame_start = (hcount==0 && vcount==0).
- Reset values (the cycle after reset is sampled high):
  - hsync = ~H_SYNC_POL, vsync = ~V_SYNC_POL, blank = 1, x = 0, y = 0, line_start = 0, frame_start = 0.
  - Both FSMs in VISIBLE.
- First cycle with enable=1 after reset: counters sit at (0,0), so the following cycle shows frame_start=1, line_start=1, blank=0.
- Reset mid-frame: immediate return to (0,0) and VISIBLE on the next edge, with no partial sync pulse extension. Reset has priority over enable.
- enable toggling: a pulse in progress stretches by exactly the number of enable=0 cycles. No strobe is duplicated or dropped.
- Zero-width porches are not supported; every parameter must be >= 1. Enforce with an elaboration-time check.

Optional Feature:
- Macro: VGA_TIMING_FRAME_COUNT_EN.
- When defined: adds output frame_count (8 bits).
  - Reset 0.
  - Increments by 1 mod 256 in the same cycle frame_start is registered high. Holds when enable=0.
  - Used to animate pattern generators.
- When undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- Defaults; reset 3 cycles, then enable=1 -> frame_start and line_start high on the 2nd enabled cycle; blank=0 with x=0, y=0.
- Line timing, defaults -> hsync low for exactly 96 cycles; blank rises at x=640, hsync falls at x=656, hsync rises at x=752; line_start period 800 cycles.
- Frame timing, defaults -> vsync low exactly on y=490 and y=491 (1600 cycles); frame_start period 420000 cycles; y wraps 524 -> 0 together with x 799 -> 0.
- enable held 0 for 37 cycles at x=700 -> all outputs frozen; the sync pulse that frame measures 96 enabled cycles (133 clocks).
- Reset asserted at x=300, y=200 for 1 cycle -> next outputs x=0, y=0, hsync/vsync inactive, blank=1; then normal frame_start.
- VGA_TIMING_FRAME_COUNT_EN defined; run 257 frames -> frame_count reads 0 -> 1 -> ... -> 255 -> 0 -> 1, each step on a frame_start cycle.
